// File: rtl/fifo_symbol_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_symbol_packer
//  Description : Drains W-bit symbols from an attached FIFO and packs K
//                consecutive symbols into one K*W-bit word. The first symbol
//                popped lands in the LSBs. Completed words are offered on a
//                valid/ready interface.
//
//                The FIFO only exposes its full flag, so the occupancy is
//                tracked here by mirroring the push/pop traffic. This shadow
//                count shares clock and reset with the FIFO, so both clear
//                together.
//
//  Ports       : clk         rising-edge clock, shared with the FIFO
//                reset       asynchronous active-low reset, shared with FIFO
//                fifo_push   copy of the upstream push strobe into the FIFO
//                fifo_full   FIFO full flag
//                fifo_out    FIFO head symbol (valid while level > 0)
//                fifo_pop    pop strobe to the FIFO
//                word_out    packed word, symbol i at [i*W +: W]
//                word_valid  word_out holds a complete word
//                word_ready  consumer accepts the word on valid & ready
//                level       shadow FIFO occupancy, 0..N
//
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_symbol_packer #(
    parameter  int N  = 4,
    parameter  int W  = 2,
    parameter  int K  = 4,
    localparam int LW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_push,
    input  logic             fifo_full,
    input  logic [W-1:0]     fifo_out,
    output logic             fifo_pop,
    output logic [K*W-1:0]   word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [LW-1:0]    level
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] C_LAST_IDX = IW'(K - 1);
    localparam logic [LW-1:0] C_LEVEL_MAX = LW'(N);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [K*W-1:0]  r_word;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_nxt;
    logic            w_level_nz;
    logic            w_acc_push;

    assign w_level_nz = (r_level != '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and pop strobe. The pop is forced low while reset is held so
    // the FIFO never sees a pop during its own reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        fifo_pop    = 1'b0;
        case (r_state)
            S_ACCUM: begin
                fifo_pop = reset & w_level_nz;
                if (fifo_pop && (r_idx == C_LAST_IDX)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                fifo_pop = reset & word_ready & w_level_nz;
                if (word_ready) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: begin
                w_state_nxt = S_ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shadow occupancy. A push into a full FIFO only lands if the same cycle
    // frees a slot. The clamps keep the count in range even if the full flag
    // and the shadow count were ever to disagree.
    // ------------------------------------------------------------------------
    assign w_acc_push = fifo_push & (~fifo_full | fifo_pop);

    always_comb begin
        w_level_nxt = r_level;
        if (w_acc_push && !fifo_pop) begin
            if (r_level != C_LEVEL_MAX) begin
                w_level_nxt = r_level + 1'b1;
            end
        end else if (!w_acc_push && fifo_pop) begin
            if (w_level_nz) begin
                w_level_nxt = r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Packing datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (fifo_pop) begin
                        for (int i = 0; i < K; i++) begin
                            if (r_idx == IW'(i)) begin
                                r_word[i*W +: W] <= fifo_out;
                            end
                        end
                        r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (word_ready) begin
                        // A pop on the handshake cycle starts the next word
                        // immediately, so a steady stream has no bubble.
                        if (fifo_pop) begin
                            r_word <= (K*W)'(fifo_out);
                            r_idx  <= IW'(1);
                        end else begin
                            r_idx  <= '0;
                        end
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign word_out   = r_word;
    assign word_valid = (r_state == S_HOLD);
    assign level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_symbol_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_symbol_packer
//  Description : Self-checking bench for fifo_symbol_packer. Models the
//                attached FIFO as a queue and the packer as a list of popped
//                symbols grouped K at a time. Directed scenarios are followed
//                by randomized traffic with occasional asynchronous resets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_symbol_packer;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int K  = 4;
    localparam int LW = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             fifo_push = 1'b0;
    logic             fifo_full = 1'b0;
    logic [W-1:0]     fifo_out = '0;
    logic             word_ready = 1'b0;
    logic             fifo_pop;
    logic [K*W-1:0]   word_out;
    logic             word_valid;
    logic [LW-1:0]    level;

    fifo_symbol_packer #(.N(N), .W(W), .K(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_push  (fifo_push),
        .fifo_full  (fifo_full),
        .fifo_out   (fifo_out),
        .fifo_pop   (fifo_pop),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .level      (level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]   fq[$];     // contents of the attached FIFO, head first
    logic [W-1:0]   part[$];   // symbols of the word being assembled
    bit             hold = 1'b0;
    logic [K*W-1:0] held_word = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic step(input bit push, input bit ready, input logic [W-1:0] d);
        bit           exp_pop;
        bit           acc;
        logic [W-1:0] sym;
        fifo_push  = push;
        word_ready = ready;
        fifo_full  = (fq.size() == N);
        fifo_out   = (fq.size() != 0) ? fq[0] : '0;
        #1;
        exp_pop = (fq.size() != 0) && (!hold || ready);
        check_eq("pop",   32'(fifo_pop),   32'(exp_pop));
        check_eq("level", 32'(level),      32'(fq.size()));
        check_eq("valid", 32'(word_valid), 32'(hold));
        if (hold) check_eq("word", 32'(word_out), 32'(held_word));
        @(posedge clk);
        acc = push && ((fq.size() < N) || exp_pop);
        sym = '0;
        if (exp_pop) sym = fq.pop_front();
        if (hold && ready) begin
            hold = 1'b0;
            part.delete();
        end
        if (exp_pop) begin
            part.push_back(sym);
            if (part.size() == K) begin
                for (int i = 0; i < K; i++) held_word[i*W +: W] = part[i];
                hold = 1'b1;
                part.delete();
            end
        end
        if (acc) fq.push_back(d);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any edge.
    task automatic pulse_reset();
        #2;
        fifo_push  = 1'b0;
        word_ready = 1'b1;
        reset      = 1'b0;
        #1;
        check_eq("rst_pop",   32'(fifo_pop),   32'h0);
        check_eq("rst_valid", 32'(word_valid), 32'h0);
        check_eq("rst_word",  32'(word_out),   32'h0);
        check_eq("rst_level", 32'(level),      32'h0);
        fq.delete();
        part.delete();
        hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset held from time zero
        #3;
        check_eq("init_pop",   32'(fifo_pop),   32'h0);
        check_eq("init_valid", 32'(word_valid), 32'h0);
        check_eq("init_word",  32'(word_out),   32'h0);
        check_eq("init_level", 32'(level),      32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, '0);
        step(0, 0, '0);

        // First word with the consumer stalled
        step(1, 0, 2'b11);
        step(1, 0, 2'b01);
        step(1, 0, 2'b10);
        step(1, 0, 2'b00);
        step(0, 0, '0);
        #1;
        check_eq("w1_valid", 32'(word_valid), 32'h1);
        check_eq("w1_word",  32'(word_out),   32'h27);

        // FIFO absorbs backpressure; the fifth push hits full and is dropped
        step(1, 0, 2'b01);
        step(1, 0, 2'b01);
        step(1, 0, 2'b10);
        step(1, 0, 2'b11);
        step(1, 0, 2'b00);
        #1;
        check_eq("bp_level", 32'(level),    32'h4);
        check_eq("bp_word",  32'(word_out), 32'h27);

        // Handshake with same-cycle pop into slot 0
        step(0, 1, '0);
        #1;
        check_eq("hs_valid", 32'(word_valid),    32'h0);
        check_eq("hs_slot0", 32'(word_out[1:0]), 32'h1);
        check_eq("hs_level", 32'(level),         32'h3);

        // Drain the rest of the second word
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 0, '0);
        #1;
        check_eq("w2_word", 32'(word_out), 32'he5);

        // Refill to N while held, then pop and push together at level N
        step(1, 0, 2'b01);
        step(1, 0, 2'b10);
        step(1, 0, 2'b11);
        step(1, 0, 2'b00);
        step(1, 1, 2'b10);
        #1;
        check_eq("full_pp_level", 32'(level), 32'h4);

        // Second symbol of the new word, then reset mid-word
        step(0, 0, '0);
        pulse_reset();
        step(1, 0, 2'b01);
        step(1, 0, 2'b10);
        step(1, 0, 2'b11);
        step(1, 0, 2'b00);
        step(0, 0, '0);
        #1;
        check_eq("post_rst_word", 32'(word_out), 32'h39);

        // Randomized traffic; probabilities shift every 100 cycles
        for (int blk = 0; blk < 8; blk++) begin
            int pp = $urandom_range(20, 95);
            int rp = $urandom_range(5, 95);
            for (int c = 0; c < 100; c++) begin
                step(($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < rp),
                     W'($urandom));
            end
            if (blk == 3) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
